// File: rtl/audio_i2s_pkg.sv
// Shared constants and types for the I2S audio path.
// Sample and frame geometry, channel encoding and the serializer state.
package audio_i2s_pkg;

   localparam int DATA_W     = 16;
   localparam int SLOT_BITS  = 16;
   localparam int FRAME_BITS = 32;
   localparam int POS_W      = $clog2(SLOT_BITS);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic LEFT  = 1'b0;
   localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/audio_clk_div.sv
// Bit-clock generator: toggles bclk every BCLK_DIV system clocks while run is high.
// rise_evt/fall_evt mark the cycle whose closing edge makes bclk rise or fall.
module audio_clk_div #(
   parameter int BCLK_DIV = 16
) (
   input  logic clk_clk,
   input  logic reset_reset_n,
   input  logic run,
   output logic bclk,
   output logic rise_evt,
   output logic fall_evt
);

   localparam int CNT_W = $clog2(BCLK_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BCLK_DIV - 1);

   logic [CNT_W-1:0] div_cnt;
   logic             terminal;

   assign terminal = run && (div_cnt == LAST);
   assign rise_evt = terminal && !bclk;
   assign fall_evt = terminal && bclk;

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (!run) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (terminal) begin
         div_cnt <= '0;
         bclk    <= ~bclk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: pulls one 16-bit sample per channel slot from a ready/valid
// source and shifts it out MSB first, one BCLK after the LRCK edge.
module audio_i2s_tx
   import audio_i2s_pkg::*;
#(
   parameter int BCLK_DIV = 16
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              enable,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              i2s_bclk,
   output logic              i2s_lrck,
   output logic              i2s_dout,
   output logic              underrun,
   output logic [15:0]       underrun_cnt
);

   localparam logic [POS_W-1:0] POS_LAST  = POS_W'(SLOT_BITS - 1);
   localparam logic [POS_W-1:0] POS_FIRST = POS_W'(1);

   state_t            state;
   logic [POS_W-1:0]  pos;
   logic [POS_W-1:0]  pos_next;
   logic              chan;
   logic [DATA_W-1:0] hold;
   logic [DATA_W-1:0] shift;
   logic              run;
   logic              fall_evt;
   logic              rise_evt_unused;
   logic              stop_now;

   assign run      = (state == RUN);
   assign pos_next = pos + 1'b1;

   // A frame boundary without enable ends the run instead of opening a left slot.
   assign stop_now = run && fall_evt && (pos == POS_LAST) && (chan == RIGHT) && !enable;
   assign in_ready = run && fall_evt && (pos == POS_LAST) && !stop_now;

   audio_clk_div #(
      .BCLK_DIV (BCLK_DIV)
   ) u_clk_div (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .run           (run),
      .bclk          (i2s_bclk),
      .rise_evt      (rise_evt_unused),
      .fall_evt      (fall_evt)
   );

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state        <= IDLE;
         pos          <= '0;
         chan         <= LEFT;
         hold         <= '0;
         shift        <= '0;
         i2s_lrck     <= 1'b1;
         i2s_dout     <= 1'b0;
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         underrun <= 1'b0;
         case (state)
            IDLE: begin
               hold     <= '0;
               shift    <= '0;
               i2s_lrck <= 1'b1;
               i2s_dout <= 1'b0;
               if (enable) begin
                  state <= RUN;
                  pos   <= POS_LAST;
                  chan  <= RIGHT;
               end
            end
            RUN: begin
               if (fall_evt) begin
                  if (stop_now) begin
                     state    <= IDLE;
                     pos      <= '0;
                     chan     <= LEFT;
                     i2s_lrck <= 1'b1;
                     i2s_dout <= 1'b0;
                  end else begin
                     pos <= pos_next;
                     if (pos_next == '0) begin
                        // Slot start: previous word's LSB goes out while LRCK flips.
                        chan     <= ~chan;
                        i2s_lrck <= ~chan;
                        i2s_dout <= shift[DATA_W-1];
                        if (in_valid) begin
                           hold <= in_data;
                        end else begin
                           hold     <= '0;
                           underrun <= 1'b1;
                           if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 1'b1;
                        end
                     end else if (pos_next == POS_FIRST) begin
                        i2s_dout <= hold[DATA_W-1];
                        shift    <= hold << 1;
                     end else begin
                        i2s_dout <= shift[DATA_W-1];
                        shift    <= shift << 1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

I2S transmitter that drains the 16-bit Avalon-ST stream leaving the audio FIFO and serializes it to a stereo DAC. It generates BCLK and LRCK from the system clock and pulls one sample per channel slot, alternating left and right. When the FIFO has no sample at the moment one is needed, the block sends silence and reports the underrun. It is the consumer end of the FIFO's ready/valid source port.

## Interface
Parameters:
- BCLK_DIV, 16: system clocks per BCLK half-period; legal values ≥2. Sample rate fs = f_clk / (64·BCLK_DIV), which is 48.8 kHz at 50 MHz.
- DATA_W, 16: sample width. It is fixed by the package and is not overridden per instance.

Ports (clock and reset first):
- clk_clk, in, 1: system clock; all logic is on its rising edge.
- reset_reset_n, in, 1: asynchronous, active-low reset.
- enable, in, 1: run request; sampled only at frame boundaries.
- in_data, in, 16: sample, two's complement.
- in_valid, in, 1: the upstream sample is valid.
- in_ready, out, 1: one-cycle pulse; a transfer occurs when in_valid && in_ready.
- i2s_bclk, out, 1: bit clock.
- i2s_lrck, out, 1: word select; 0 = left, 1 = right.
- i2s_dout, out, 1: serial data, MSB first.
- underrun, out, 1: one-cycle pulse when a slot starts without a sample.
- underrun_cnt, out, 16: saturating count of underruns.

## Operation
Divider:
- div_cnt counts 0..BCLK_DIV-1. When div_cnt = BCLK_DIV-1, i2s_bclk toggles.
- A fall event is the cycle with div_cnt = BCLK_DIV-1 and bclk = 1. All serial state advances only on fall events.

Slot position:
- pos counts 0..15 and chan is 0 (left) or 1 (right). Each fall event increments pos.
- When pos wraps 15→0, chan toggles and i2s_lrck takes the new chan.

Behaviour at each fall event:
- At pos 0, in_ready is 1 for that cycle. If in_valid is also 1, hold ← in_data. Otherwise hold ← 0, underrun pulses and underrun_cnt increments, saturating at 0xFFFF. In both cases dout ← shift[15], which is the LSB of the previous word.
- At pos 1, dout ← hold[15] and shift ← hold << 1. This gives the standard I2S one-BCLK delay after the LRCK edge.
- At pos 2..15, dout ← shift[15] and shift ← shift << 1.

States:
- IDLE: bclk = 0, lrck = 1, dout = 0, div_cnt held at 0, in_ready = 0.
  - If enable is 1, go to RUN with pos = 15 and chan = 1, so the first fall event starts a left slot.
- RUN: divider and serializer operate as above.
  - At a fall event with pos = 15 and chan = 1, enable is sampled. If it is 0, go to IDLE instead of starting a new frame.
  - Therefore a started frame always completes; the final LSB is not emitted, because IDLE forces dout to 0.

Rules:
- Word ordering: the first word after entering RUN is left. The block never reorders words and never drops an accepted word.
- in_ready never asserts outside a pos-0 fall event, so at most one word is taken per slot.
- Asynchronous reset mid-operation clears everything immediately. Any partially shifted word is discarded and no word is lost from the FIFO beyond the one already captured.

## Timing
- Reset values: i2s_bclk = 0, i2s_lrck = 1, i2s_dout = 0, in_ready = 0, underrun = 0, underrun_cnt = 0. State is IDLE, with div_cnt, pos, hold and shift all 0.
- All outputs are registered; i2s_* change on the clock edge that ends a fall-event cycle.
- In_ready is combinational from state (fall event && pos = 0 && RUN), asserted for exactly one cycle per slot.
- Latency:
  - An accepted word's MSB appears on dout one BCLK (2·BCLK_DIV clocks) after its in_ready cycle.
  - Its LSB appears 16 BCLKs after its in_ready cycle.
- enable → first falling BCLK edge: BCLK_DIV + 1·BCLK_DIV clocks, i.e. one rise then one fall.
- BCLK duty is 50%. There are 32 BCLKs per frame and LRCK changes only on falling BCLK.

## Structure
- Package audio_i2s_pkg holds:
  - DATA_W = 16, SLOT_BITS = 16 and FRAME_BITS = 32;
  - the state enum {IDLE, RUN};
  - the channel constants LEFT = 0 and RIGHT = 1.
- Sub-module audio_clk_div (parameter BCLK_DIV, inputs run and clk_clk/reset_reset_n, outputs bclk, rise_evt and fall_evt) holds the divider. It is reused by the planned I2S receiver.
- The top level holds pos/chan, hold, shift, the underrun logic and the state register.

## Test plan
- Reset, then enable with BCLK_DIV = 4 and a source supplying 0x8001 (left) then 0x7FFE (right):
  - the lrck falling edge comes first;
  - dout bits are 1,000…0001 then 0,111…1110, each starting one BCLK after its lrck edge;
  - in_ready pulses exactly 2 times per frame.
- in_valid held low: dout is all zeros, underrun pulses every slot, underrun_cnt = 4 after 2 frames, and lrck/bclk keep running.
- Underrun counter saturation: with underrun_cnt preset to 0xFFFE by forcing, 3 more underruns leave it at 0xFFFF.
- enable dropped mid-left slot:
  - the right slot of that frame completes;
  - the block then goes to IDLE (bclk = 0, lrck = 1, dout = 0);
  - no further in_ready.
- reset_reset_n pulsed low at pos 7:
  - all outputs reach their reset values within the same cycle, asynchronously;
  - after re-enable, the next accepted word goes to the left slot.
- Randomized in_valid gaps with a sample scoreboard:
  - every accepted word appears on the correct channel, in order;
  - the number of zero slots equals underrun_cnt.
